nor3_sweep_controller: RTL and testbench
========================================

# nor3_sweep_controller

Self-checking sweep controller for a 3-input NOR gate under test. On a start pulse it drives all eight input patterns onto the gate's `a`/`b`/`c` inputs in binary order, with `c` toggling fastest. After each pattern it waits a programmable settle time, samples the gate output, and compares it against the expected NOR value. It sits between the board-level start button/LEDs and the combinational NOR gate and reports pass/fail, error count and the first failing pattern.

## Interface

Parameters:

- `SETTLE_CYCLES`, default 4. Clock cycles each pattern is held before sampling. Legal range is 1..15; 0 is illegal.

Ports:

- `clk`  input  1  Single system clock. All state changes on the rising edge.
- `rst_n`  input  1  Reset. Synchronous, active-low.
- `start`  input  1  Sweep request. Level sampled on the rising edge.
- `d_in`  input  1  Output of the NOR gate under test.
- `a`  output  1  Gate input a, equal to `pattern[2]`. Registered.
- `b`  output  1  Gate input b, equal to `pattern[1]`. Registered.
- `c`  output  1  Gate input c, equal to `pattern[0]`. Registered.
- `exp_d`  output  1  Expected output, `~(a|b|c)`. Combinational from the registered `a`/`b`/`c`.
- `busy`  output  1  High in SETTLE and SAMPLE.
- `done`  output  1  High in DONE.
- `pass`  output  1  High in DONE when `err_count == 0`; otherwise 0.
- `err_count`  output  4  Number of mismatching patterns in the current or last sweep, 0..8.
- `fail_pattern`  output  3  `{a,b,c}` of the first mismatch. Valid only when `err_count != 0`.

## Operation

States: IDLE, SETTLE, SAMPLE, DONE. Internal registers are the 3-bit `pattern`, the 4-bit `settle_cnt`, `err_count` and `fail_pattern`.

- **Reset** (`rst_n == 0` at an edge): the FSM goes to IDLE. `pattern`, `settle_cnt`, `err_count` and `fail_pattern` clear to 0. `a`, `b`, `c`, `busy`, `done` and `pass` are 0, so `exp_d = 1`. Reset overrides every other condition, including mid-sweep.
- **IDLE**, `start == 1`: go to SETTLE. Set `pattern = 0`, `settle_cnt = 0`, `err_count = 0`, `fail_pattern = 0`. With `start == 0`, stay in IDLE.
- **SETTLE**: increment `settle_cnt` each cycle. When `settle_cnt == SETTLE_CYCLES-1`, go to SAMPLE. `d_in` is ignored in this state.
- **SAMPLE**: compare `d_in` against `exp_d`.
  - On a mismatch, increment `err_count`. If `err_count` was 0, also latch `fail_pattern = pattern`.
  - If `pattern == 7`, go to DONE.
  - Otherwise increment `pattern`, clear `settle_cnt`, and go to SETTLE.
- **DONE**: hold `pattern = 7` on `a`/`b`/`c` and hold all results.
  - `start == 1` restarts the sweep exactly as from IDLE, including clearing the results.
  - `start == 0`: stay in DONE indefinitely.
- `start` is ignored while `busy == 1`.
- Width rules:
  - `pattern` increments without wrap; the 7 → 0 transition never occurs within a sweep.
  - `err_count` has a maximum of 8, which fits in 4 bits, so no saturation is needed.
- `start` is level-sensitive. If it is held high through DONE, the controller restarts on the first DONE cycle. Benches must pulse `start` for one cycle unless they intend a restart.

## Timing

- Let edge E0 be the first edge at which `start == 1` in IDLE or DONE. At E0, `a`/`b`/`c` become 000 and `busy` rises.
- Each pattern occupies `SETTLE_CYCLES + 1` cycles: SETTLE_CYCLES cycles of settling, then 1 cycle of SAMPLE.
- `d_in` for pattern k is sampled at edge E0 + (k+1)·(SETTLE_CYCLES+1).
- `a`/`b`/`c` change to pattern k+1 at that same edge.
- `done` rises, and `busy` falls, at edge E0 + 8·(SETTLE_CYCLES+1). This is edge E0+40 at the default.
- `pass`, `err_count` and `fail_pattern` are stable from that edge onward.
- `err_count` and `fail_pattern` update at the SAMPLE edge, so mid-sweep values are visible one cycle after each sample.
- The NOR gate is combinational. Its output must settle within SETTLE_CYCLES clock periods.

## Test plan

1. **Correct NOR model**, `d_in = ~(a|b|c)`, `SETTLE_CYCLES = 4`, 1-cycle start pulse:
   - `a`/`b`/`c` step 000 → 111, 5 cycles each.
   - `done` rises at E0+40 with `pass = 1`, `err_count = 0`.
2. **Stuck-at-0 DUT** (`d_in = 0`):
   - `done` with `pass = 0`, `err_count = 1`, `fail_pattern = 3'b000`.
   - Then pulse `start` in DONE with a correct DUT: `err_count` clears at E0 and the sweep ends with `pass = 1`.
3. **Stuck-at-1 DUT** (`d_in = 1`):
   - `err_count = 7`, `fail_pattern = 3'b001`, `pass = 0`.
4. **Reset mid-sweep**: drive `rst_n = 0` for one edge while `pattern = 3`.
   - At that edge, all outputs go to 0, `exp_d = 1`, and the FSM is in IDLE.
   - A subsequent start produces a full clean sweep, `done` at E0+40.
5. **Start during busy and settle glitch**:
   - Assert `start` again while `pattern = 2`: no effect on `pattern` or timing.
   - Invert `d_in` during SETTLE cycles only, correct during SAMPLE: result is `pass = 1`, `err_count = 0`.
6. **Minimum settle**, `SETTLE_CYCLES = 1`:
   - Each pattern lasts 2 cycles.
   - `done` at E0+16.
   - A correct DUT gives `pass = 1`.

Source files
------------

// File: rtl/nor3_sweep_controller.sv
// nor3_sweep_controller
// Sweeps all eight {a,b,c} patterns onto a 3-input NOR gate under test.
// For each pattern it waits SETTLE_CYCLES, samples d_in once, and compares
// the sample against the expected NOR value. Results are the error count
// and the first failing pattern, held in DONE until the next start.
module nor3_sweep_controller #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       d_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       exp_d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_pattern
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last settle count before sampling; SETTLE_CYCLES must lie in 1..15.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  pattern;
  logic [3:0]  settle_cnt;
  logic        launch;
  logic        mismatch;

  function automatic logic nor3(input logic [2:0] p);
    return ~(|p);
  endfunction

  // Gate inputs come straight from the pattern register.
  assign a = pattern[2];
  assign b = pattern[1];
  assign c = pattern[0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = (pattern == 3'd7) ? S_DONE : S_SETTLE;
      S_DONE:   if (start) state_nxt = S_SETTLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Status outputs and the per-cycle compare decode.
  always_comb begin
    busy     = (state == S_SETTLE) || (state == S_SAMPLE);
    done     = (state == S_DONE);
    pass     = done && (err_count == 4'd0);
    exp_d    = nor3({a, b, c});
    launch   = start && ((state == S_IDLE) || (state == S_DONE));
    mismatch = (state == S_SAMPLE) && (d_in != exp_d);
  end

  // Pattern stepping, settle timer and result capture.
  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      pattern      <= 3'd0;
      settle_cnt   <= 4'd0;
      err_count    <= 4'd0;
      fail_pattern <= 3'd0;
    end else begin
      case (state)
        S_SETTLE: settle_cnt <= settle_cnt + 4'd1;
        S_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 4'd1;
            if (err_count == 4'd0) fail_pattern <= pattern;
          end
          // Pattern 7 is held through DONE; the counter never wraps.
          if (pattern != 3'd7) begin
            pattern    <= pattern + 3'd1;
            settle_cnt <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nor3_sweep_controller.sv
// Directed bench for nor3_sweep_controller: one instance at the default
// settle time and one at the minimum settle time, each driven by a small
// NOR-gate model that can be stuck or glitched.
module tb_nor3_sweep_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sel;     // 0 -> default instance, 1 -> minimum-settle instance
  logic [1:0] mode;    // 0 correct, 1 stuck-at-0, 2 stuck-at-1
  logic       inv;     // invert model output (settle glitch)

  logic       start1, d_in1, a1, b1, c1, exp_d1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] fail1;
  logic       start2, d_in2, a2, b2, c2, exp_d2, busy2, done2, pass2;
  logic [3:0] err2;
  logic [2:0] fail2;

  logic [2:0] obs_abc;
  logic       obs_exp, obs_busy, obs_done, obs_pass;
  logic [3:0] obs_err;
  logic [2:0] obs_fail;

  int errors = 0;
  int checks = 0;

  nor3_sweep_controller #(.SETTLE_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .d_in(d_in1),
    .a(a1), .b(b1), .c(c1), .exp_d(exp_d1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_pattern(fail1)
  );

  nor3_sweep_controller #(.SETTLE_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .d_in(d_in2),
    .a(a2), .b(b2), .c(c2), .exp_d(exp_d2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_pattern(fail2)
  );

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign d_in1  = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : (~(a1 | b1 | c1)) ^ inv;
  assign d_in2  = (mode == 2'd1) ? 1'b0 : (mode == 2'd2) ? 1'b1 : (~(a2 | b2 | c2)) ^ inv;

  assign obs_abc  = sel ? {a2, b2, c2} : {a1, b1, c1};
  assign obs_exp  = sel ? exp_d2 : exp_d1;
  assign obs_busy = sel ? busy2  : busy1;
  assign obs_done = sel ? done2  : done1;
  assign obs_pass = sel ? pass2  : pass1;
  assign obs_err  = sel ? err2   : err1;
  assign obs_fail = sel ? fail2  : fail1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulse start for edge E0, then follow the sweep edge by edge to DONE.
  task automatic run_sweep(input int per, input bit glitch, input bit poke);
    int total;
    int m;
    total = 8 * per;
    start = 1'b1;
    inv   = 1'b0;
    tick();
    start = 1'b0;
    check("e0_abc",  32'(obs_abc),  32'd0);
    check("e0_busy", 32'(obs_busy), 32'd1);
    check("e0_err",  32'(obs_err),  32'd0);
    check("e0_expd", 32'(obs_exp),  32'd1);
    for (int n = 0; n < total - 1; n++) begin
      // Inputs for edge n+1: glitch everywhere except at sample edges.
      inv   = glitch && (((n + 1) % per) != 0);
      start = poke && (n == 2 * per + 1);
      tick();
      m = n + 1;
      check("abc_step", 32'(obs_abc),  32'(m / per));
      check("done_lo",  32'(obs_done), 32'd0);
    end
    inv   = 1'b0;
    start = 1'b0;
    tick();
    check("done_edge", 32'(obs_done), 32'd1);
    check("busy_end",  32'(obs_busy), 32'd0);
    check("abc_end",   32'(obs_abc),  32'd7);
  endtask

  task automatic check_result(input string tag, input logic p, input logic [3:0] e,
                              input logic [2:0] f);
    check({tag, "_pass"}, 32'(obs_pass), 32'(p));
    check({tag, "_err"},  32'(obs_err),  32'(e));
    if (e != 4'd0) check({tag, "_fail"}, 32'(obs_fail), 32'(f));
  endtask

  initial begin
    sel   = 1'b0;
    mode  = 2'd0;
    inv   = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_abc",  32'({a1, b1, c1}), 32'd0);
    check("rst_expd", 32'(exp_d1), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_pass", 32'(pass1), 32'd0);
    check("rst_err",  32'(err1),  32'd0);
    check("rst_fail", 32'(fail1), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(busy1), 32'd0);

    // Correct gate.
    run_sweep(5, 1'b0, 1'b0);
    check_result("t1", 1'b1, 4'd0, 3'd0);
    repeat (3) tick();
    check("hold_done", 32'(obs_done), 32'd1);
    check("hold_abc",  32'(obs_abc),  32'd7);

    // Stuck-at-0: only pattern 000 expects 1.
    mode = 2'd1;
    run_sweep(5, 1'b0, 1'b0);
    check_result("sa0", 1'b0, 4'd1, 3'b000);

    // Restart from DONE with a correct gate clears the results.
    mode = 2'd0;
    run_sweep(5, 1'b0, 1'b0);
    check_result("restart", 1'b1, 4'd0, 3'd0);

    // Stuck-at-1: patterns 001..111 all expect 0.
    mode = 2'd2;
    run_sweep(5, 1'b0, 1'b0);
    check_result("sa1", 1'b0, 4'd7, 3'b001);

    // Reset while pattern 3 is on the gate.
    mode  = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("pre_rst_abc", 32'({a1, b1, c1}), 32'd3);
    rst_n = 1'b0;
    tick();
    check("mid_rst_abc",  32'({a1, b1, c1}), 32'd0);
    check("mid_rst_expd", 32'(exp_d1), 32'd1);
    check("mid_rst_busy", 32'(busy1), 32'd0);
    check("mid_rst_done", 32'(done1), 32'd0);
    check("mid_rst_err",  32'(err1),  32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 32'(busy1), 32'd0);
    run_sweep(5, 1'b0, 1'b0);
    check_result("after_rst", 1'b1, 4'd0, 3'd0);

    // Start poked mid-sweep plus glitches confined to SETTLE.
    run_sweep(5, 1'b1, 1'b1);
    check_result("glitch", 1'b1, 4'd0, 3'd0);

    // Minimum settle instance.
    sel = 1'b1;
    tick();
    check("min_idle", 32'(obs_busy), 32'd0);
    run_sweep(2, 1'b0, 1'b0);
    check_result("min", 1'b1, 4'd0, 3'd0);
    mode = 2'd2;
    run_sweep(2, 1'b0, 1'b0);
    check_result("min_sa1", 1'b0, 4'd7, 3'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
